// File: rtl/traffic_light_safety_monitor.sv
// traffic_light_safety_monitor
//   Sits between the traffic light controller and the lamp drivers. It passes
//   the four lamp heads through with one cycle of latency and checks every
//   sample. On a violation it latches a fault and drives flashing red until
//   the operator clears it and an all-red recovery interval has completed.
//
// Ports
//   clk, rst                 clock (rising edge), async active-high reset
//   light_M1/S/MT/M2 [2:0]   lamp heads from the controller, {red,yellow,green}
//   clr_fault                operator fault clear, level-sampled
//   out_M1/S/MT/M2 [2:0]     registered lamp drive
//   fault                    high while in FAILSAFE
//   fault_code [2:0]         first-fault cause (1 illegal, 2 conflict,
//                            3 green->red skip, 4 stuck), sticky until cleared
//   flash                    failsafe flash phase, 1 = red lit
module traffic_light_safety_monitor #(
   parameter int MAX_HOLD       = 256,
   parameter int FLASH_HALF     = 25,
   parameter int ALL_RED_CYCLES = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] light_M1,
   input  logic [2:0] light_S,
   input  logic [2:0] light_MT,
   input  logic [2:0] light_M2,
   input  logic       clr_fault,
   output logic [2:0] out_M1,
   output logic [2:0] out_S,
   output logic [2:0] out_MT,
   output logic [2:0] out_M2,
   output logic       fault,
   output logic [2:0] fault_code,
   output logic       flash
);

   localparam logic [2:0]  RED   = 3'b100;
   localparam logic [2:0]  YEL   = 3'b010;
   localparam logic [2:0]  GRN   = 3'b001;
   localparam logic [2:0]  DARK  = 3'b000;
   localparam logic [15:0] HOLD_LIM   = 16'(MAX_HOLD);
   localparam logic [15:0] FLASH_LAST = 16'(FLASH_HALF - 1);
   localparam logic [15:0] REC_LAST   = 16'(ALL_RED_CYCLES - 1);

   typedef enum logic [1:0] {NORMAL, FAILSAFE, RECOVER} state_t;

   state_t            state;
   logic [3:0][2:0]   lamp;      // index 0 = M1, 1 = S, 2 = MT, 3 = M2
   logic [3:0][2:0]   prev;
   logic [3:0][2:0]   outs;
   logic [3:0][15:0]  hold;
   logic [3:0][15:0]  hold_nxt;
   logic [15:0]       rec_cnt;
   logic [15:0]       flash_cnt;
   logic              illegal, conflict, skip, stuck, dirty;
   logic [2:0]        code;

   assign lamp   = {light_M2, light_MT, light_S, light_M1};
   assign out_M1 = outs[0];
   assign out_S  = outs[1];
   assign out_MT = outs[2];
   assign out_M2 = outs[3];

   // All checks look at the raw inputs against the last accepted sample, so a
   // bad sample is caught before it can be registered onto the outputs.
   always_comb begin
      illegal  = 1'b0;
      skip     = 1'b0;
      stuck    = 1'b0;
      hold_nxt = hold;
      for (int i = 0; i < 4; i++) begin
         if (!(lamp[i] == RED || lamp[i] == YEL || lamp[i] == GRN)) illegal = 1'b1;
         if (prev[i] == GRN && lamp[i] == RED) skip = 1'b1;
         if (lamp[i] != prev[i])
            hold_nxt[i] = '0;
         else if (hold[i] != 16'hFFFF)
            hold_nxt[i] = hold[i] + 16'd1;
         // The entry/change cycle counts as zero, so the fault lands exactly
         // MAX_HOLD cycles after the last change.
         if (hold_nxt[i] >= HOLD_LIM) stuck = 1'b1;
      end
      // Side green may not overlap any main green; turn may not overlap main 2.
      conflict = (lamp[1][0] & (lamp[0][0] | lamp[2][0] | lamp[3][0])) |
                 (lamp[2][0] & lamp[3][0]);
      dirty    = illegal | conflict;
      if (illegal)                          code = 3'd1;
      else if (conflict)                    code = 3'd2;
      else if (state == NORMAL && skip)     code = 3'd3;
      else if (state == NORMAL && stuck)    code = 3'd4;
      else                                  code = 3'd0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= RECOVER;
         outs       <= {4{RED}};
         prev       <= {4{RED}};
         hold       <= '0;
         rec_cnt    <= '0;
         flash_cnt  <= '0;
         flash      <= 1'b0;
         fault      <= 1'b0;
         fault_code <= '0;
      end else begin
         hold <= hold_nxt;
         case (state)
            NORMAL: begin
               if (code != 3'd0) begin
                  state      <= FAILSAFE;
                  fault      <= 1'b1;
                  fault_code <= code;
                  flash      <= 1'b1;
                  flash_cnt  <= '0;
                  outs       <= {4{RED}};
               end else begin
                  outs <= lamp;
                  prev <= lamp;
               end
            end
            FAILSAFE: begin
               if (clr_fault && !dirty) begin
                  state      <= RECOVER;
                  fault      <= 1'b0;
                  fault_code <= '0;
                  flash      <= 1'b0;
                  rec_cnt    <= '0;
                  outs       <= {4{RED}};
               end else if (flash_cnt == FLASH_LAST) begin
                  // Outputs follow the new phase in the same cycle as flash.
                  flash     <= ~flash;
                  flash_cnt <= '0;
                  outs      <= flash ? {4{DARK}} : {4{RED}};
               end else begin
                  flash_cnt <= flash_cnt + 16'd1;
               end
            end
            RECOVER: begin
               if (dirty) begin
                  state      <= FAILSAFE;
                  fault      <= 1'b1;
                  fault_code <= code;
                  flash      <= 1'b1;
                  flash_cnt  <= '0;
                  outs       <= {4{RED}};
               end else if (rec_cnt == REC_LAST) begin
                  state   <= NORMAL;
                  rec_cnt <= '0;
                  outs    <= lamp;
                  prev    <= lamp;
                  hold    <= '0;
               end else begin
                  rec_cnt <= rec_cnt + 16'd1;
               end
            end
            default: state <= RECOVER;
         endcase
      end
   end

endmodule
